// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: requests aligned 8-byte instruction pairs from
// instruction memory and writes them into two downstream queue lanes.
// One transaction may be outstanding at a time. When a queue lane is full
// at completion, the pair is parked in hold registers until both lanes
// have room. A redirect flushes everything and restarts fetch at a new
// address. If a request is still in flight when the redirect arrives, that
// request is allowed to finish and its data is dropped.

module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_fetch_en,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [63:0] i_imem_rdata,
  input  logic        i_q1_full,
  input  logic        i_q2_full,
  output logic [31:0] o_instruction_1,
  output logic [31:0] o_instruction_2,
  output logic        o_instruction1_valid,
  output logic        o_instruction2_valid,
  output logic [31:0] o_fetch_pc
);

  // Fetch addresses are always pair aligned, so the low three bits are forced to zero
  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:3], 3'b000};

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD
  } fetchState_t;

  fetchState_t r_state;
  fetchState_t w_nextState;

  logic [31:0] r_fetchPc;
  logic        r_imemReq;
  logic [31:0] r_imemAddr;
  logic [31:0] r_instr1;
  logic [31:0] r_instr2;
  logic        r_valid;
  logic [31:0] r_hold1;
  logic [31:0] r_hold2;
  logic        r_discard;

  logic [31:0] w_nextFetchPc;
  logic        w_nextImemReq;
  logic [31:0] w_nextImemAddr;
  logic [31:0] w_nextInstr1;
  logic [31:0] w_nextInstr2;
  logic        w_nextValid;
  logic [31:0] w_nextHold1;
  logic [31:0] w_nextHold2;
  logic        w_nextDiscard;

  logic        w_complete;
  logic        w_queueReady;
  logic [31:0] w_redirectPc;
  logic [31:0] w_pcPlus8;
  logic        w_unusedRedirectLowBits;

  assign w_complete   = r_imemReq & i_imem_ack;
  assign w_queueReady = ~i_q1_full & ~i_q2_full;
  assign w_redirectPc = {i_redirect_pc[31:3], 3'b000};
  assign w_pcPlus8    = r_fetchPc + 32'd8;

  // The low redirect bits carry no information for an aligned fetch address
  assign w_unusedRedirectLowBits = &i_redirect_pc[2:0];

  // State register; reset abandons any transaction in flight
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and datapath decisions; redirect always takes priority
  always_comb begin
    w_nextState    = r_state;
    w_nextFetchPc  = r_fetchPc;
    w_nextImemReq  = 1'b0;
    w_nextImemAddr = r_imemAddr;
    w_nextInstr1   = r_instr1;
    w_nextInstr2   = r_instr2;
    w_nextValid    = 1'b0;
    w_nextHold1    = r_hold1;
    w_nextHold2    = r_hold2;
    w_nextDiscard  = r_discard;

    case (r_state)
      IDLE: begin
        if (i_redirect_valid) begin
          w_nextFetchPc = w_redirectPc;
          w_nextHold1   = 32'h0;
          w_nextHold2   = 32'h0;
          w_nextDiscard = 1'b0;
          if (i_fetch_en) begin
            w_nextState    = REQ;
            w_nextImemReq  = 1'b1;
            w_nextImemAddr = w_redirectPc;
          end
        end else if (i_fetch_en) begin
          w_nextState    = REQ;
          w_nextImemReq  = 1'b1;
          w_nextImemAddr = r_fetchPc;
        end
      end

      REQ: begin
        if (w_complete) begin
          if (i_redirect_valid || r_discard) begin
            // Returned pair belongs to a flushed stream: drop it, no increment
            if (i_redirect_valid) begin
              w_nextFetchPc = w_redirectPc;
              w_nextHold1   = 32'h0;
              w_nextHold2   = 32'h0;
            end
            w_nextDiscard = 1'b0;
            if (i_fetch_en) begin
              w_nextState    = REQ;
              w_nextImemReq  = 1'b1;
              w_nextImemAddr = i_redirect_valid ? w_redirectPc : r_fetchPc;
            end else begin
              w_nextState = IDLE;
            end
          end else if (w_queueReady) begin
            w_nextInstr1  = i_imem_rdata[31:0];
            w_nextInstr2  = i_imem_rdata[63:32];
            w_nextValid   = 1'b1;
            w_nextFetchPc = w_pcPlus8;
            if (i_fetch_en) begin
              w_nextState    = REQ;
              w_nextImemReq  = 1'b1;
              w_nextImemAddr = w_pcPlus8;
            end else begin
              w_nextState = IDLE;
            end
          end else begin
            w_nextHold1   = i_imem_rdata[31:0];
            w_nextHold2   = i_imem_rdata[63:32];
            w_nextFetchPc = w_pcPlus8;
            w_nextState   = HOLD;
          end
        end else begin
          // Request stays up at its original address until acknowledged
          w_nextImemReq = 1'b1;
          if (i_redirect_valid) begin
            w_nextFetchPc = w_redirectPc;
            w_nextHold1   = 32'h0;
            w_nextHold2   = 32'h0;
            w_nextDiscard = 1'b1;
          end
        end
      end

      HOLD: begin
        if (i_redirect_valid) begin
          w_nextFetchPc = w_redirectPc;
          w_nextHold1   = 32'h0;
          w_nextHold2   = 32'h0;
          w_nextDiscard = 1'b0;
          if (i_fetch_en) begin
            w_nextState    = REQ;
            w_nextImemReq  = 1'b1;
            w_nextImemAddr = w_redirectPc;
          end else begin
            w_nextState = IDLE;
          end
        end else if (w_queueReady) begin
          w_nextInstr1 = r_hold1;
          w_nextInstr2 = r_hold2;
          w_nextValid  = 1'b1;
          if (i_fetch_en) begin
            w_nextState    = REQ;
            w_nextImemReq  = 1'b1;
            w_nextImemAddr = r_fetchPc;
          end else begin
            w_nextState = IDLE;
          end
        end
      end

      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Datapath registers follow the decisions made above
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_fetchPc  <= RESET_PC_ALIGNED;
      r_imemReq  <= 1'b0;
      r_imemAddr <= 32'h0;
      r_instr1   <= 32'h0;
      r_instr2   <= 32'h0;
      r_valid    <= 1'b0;
      r_hold1    <= 32'h0;
      r_hold2    <= 32'h0;
      r_discard  <= 1'b0;
    end else begin
      r_fetchPc  <= w_nextFetchPc;
      r_imemReq  <= w_nextImemReq;
      r_imemAddr <= w_nextImemAddr;
      r_instr1   <= w_nextInstr1;
      r_instr2   <= w_nextInstr2;
      r_valid    <= w_nextValid;
      r_hold1    <= w_nextHold1;
      r_hold2    <= w_nextHold2;
      r_discard  <= w_nextDiscard;
    end
  end

  assign o_imem_req           = r_imemReq;
  assign o_imem_addr          = r_imemAddr;
  assign o_instruction_1      = r_instr1;
  assign o_instruction_2      = r_instr2;
  assign o_instruction1_valid = r_valid;
  assign o_instruction2_valid = r_valid;
  assign o_fetch_pc           = r_fetchPc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit: streaming, backpressure, redirects,
// stop, address wrap and asynchronous reset, with hand-computed expectations.

module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic        fetchEn;
  logic        redirectValid;
  logic [31:0] redirectPc;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [63:0] imemRdata;
  logic        q1Full;
  logic        q2Full;
  logic [31:0] instr1;
  logic [31:0] instr2;
  logic        valid1;
  logic        valid2;
  logic [31:0] fetchPc;

  int passCount;
  int totalCount;

  instr_fetch_unit #(.RESET_PC(32'h0000_0003)) dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_fetch_en          (fetchEn),
    .i_redirect_valid    (redirectValid),
    .i_redirect_pc       (redirectPc),
    .o_imem_req          (imemReq),
    .o_imem_addr         (imemAddr),
    .i_imem_ack          (imemAck),
    .i_imem_rdata        (imemRdata),
    .i_q1_full           (q1Full),
    .i_q2_full           (q2Full),
    .o_instruction_1     (instr1),
    .o_instruction_2     (instr2),
    .o_instruction1_valid(valid1),
    .o_instruction2_valid(valid2),
    .o_fetch_pc          (fetchPc)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory content model: each word is its address with a fixed tag mixed in
  function automatic logic [31:0] wordAt(input logic [31:0] a);
    return a ^ 32'h5EED_0000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of inputs, then advance past the next rising edge
  task automatic applyStimulus(input logic fe, input logic ack, input logic [31:0] rdAddr,
                               input logic f1, input logic f2,
                               input logic rv, input logic [31:0] rpc);
    fetchEn       = fe;
    imemAck       = ack;
    imemRdata     = {wordAt(rdAddr + 32'd4), wordAt(rdAddr)};
    q1Full        = f1;
    q2Full        = f2;
    redirectValid = rv;
    redirectPc    = rpc;
    tick();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalCount++;
    assert (observed === expected) begin
      passCount++;
    end else begin
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Request, address, both valids and fetch pc in one go
  task automatic checkCore(input string tag, input logic req, input logic [31:0] addr,
                           input logic vld, input logic [31:0] pc);
    checkOutput({tag, ".req"}, {31'b0, imemReq}, {31'b0, req});
    checkOutput({tag, ".addr"}, imemAddr, addr);
    checkOutput({tag, ".valid1"}, {31'b0, valid1}, {31'b0, vld});
    checkOutput({tag, ".valid2"}, {31'b0, valid2}, {31'b0, vld});
    checkOutput({tag, ".pc"}, fetchPc, pc);
  endtask

  task automatic checkData(input string tag, input logic [31:0] pairAddr);
    checkOutput({tag, ".instr1"}, instr1, wordAt(pairAddr));
    checkOutput({tag, ".instr2"}, instr2, wordAt(pairAddr + 32'd4));
  endtask

  initial begin
    passCount     = 0;
    totalCount    = 0;
    rst           = 1'b1;
    fetchEn       = 1'b0;
    imemAck       = 1'b0;
    imemRdata     = 64'h0;
    q1Full        = 1'b0;
    q2Full        = 1'b0;
    redirectValid = 1'b0;
    redirectPc    = 32'h0;

    $display("[TB] reset");
    tick();
    tick();
    checkCore("reset", 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("reset.instr1", instr1, 32'h0);
    checkOutput("reset.instr2", instr2, 32'h0);

    // First request only after reset release
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkCore("first_req", 1'b1, 32'h0, 1'b0, 32'h0);

    $display("[TB] streaming");
    applyStimulus(1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkCore("stream0", 1'b1, 32'h8, 1'b1, 32'h8);
    checkData("stream0", 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h8, 1'b0, 1'b0, 1'b0, 32'h0);
    checkCore("stream8", 1'b1, 32'h10, 1'b1, 32'h10);
    checkData("stream8", 32'h8);
    applyStimulus(1'b1, 1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 32'h0);
    checkCore("stream10", 1'b1, 32'h18, 1'b1, 32'h18);
    checkData("stream10", 32'h10);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkCore("wait18", 1'b1, 32'h18, 1'b0, 32'h18);

    $display("[TB] stop mid-request");
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkCore("stop_pending", 1'b1, 32'h18, 1'b0, 32'h18);
    applyStimulus(1'b0, 1'b1, 32'h18, 1'b0, 1'b0, 1'b0, 32'h0);
    checkCore("stop_done", 1'b0, 32'h18, 1'b1, 32'h20);
    checkData("stop_done", 32'h18);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkCore("stop_idle", 1'b0, 32'h18, 1'b0, 32'h20);

    $display("[TB] redirect in flight");
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkCore("req20", 1'b1, 32'h20, 1'b0, 32'h20);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h104);
    checkCore("redir_pending", 1'b1, 32'h20, 1'b0, 32'h100);
    applyStimulus(1'b1, 1'b1, 32'h20, 1'b0, 1'b0, 1'b0, 32'h0);
    checkCore("redir_drop", 1'b1, 32'h100, 1'b0, 32'h100);
    checkData("redir_drop_keep", 32'h18);

    $display("[TB] backpressure");
    applyStimulus(1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0);
    checkCore("bp100", 1'b1, 32'h108, 1'b1, 32'h108);
    checkData("bp100", 32'h100);
    applyStimulus(1'b1, 1'b1, 32'h108, 1'b0, 1'b1, 1'b0, 32'h0);
    checkCore("bp_hold0", 1'b0, 32'h108, 1'b0, 32'h110);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    checkCore("bp_hold1", 1'b0, 32'h108, 1'b0, 32'h110);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    checkCore("bp_hold2", 1'b0, 32'h108, 1'b0, 32'h110);
    checkData("bp_hold_keep", 32'h100);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkCore("bp_release", 1'b1, 32'h110, 1'b1, 32'h110);
    checkData("bp_release", 32'h108);

    $display("[TB] redirect at completion and wrap");
    applyStimulus(1'b1, 1'b1, 32'h110, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    checkCore("redir_complete", 1'b1, 32'hFFFF_FFF8, 1'b0, 32'hFFFF_FFF8);
    checkData("redir_complete_keep", 32'h108);
    applyStimulus(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0, 1'b0, 1'b0, 32'h0);
    checkCore("wrap", 1'b1, 32'h0, 1'b1, 32'h0);
    checkData("wrap", 32'hFFFF_FFF8);

    $display("[TB] redirect in hold");
    applyStimulus(1'b1, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    checkCore("hold_q1", 1'b0, 32'h0, 1'b0, 32'h8);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h200);
    checkCore("hold_redir", 1'b1, 32'h200, 1'b0, 32'h200);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkCore("hold_discarded", 1'b1, 32'h200, 1'b0, 32'h200);
    checkData("hold_discarded_keep", 32'hFFFF_FFF8);

    $display("[TB] async reset mid-request");
    applyStimulus(1'b1, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 32'h0);
    checkCore("pre_reset", 1'b1, 32'h208, 1'b1, 32'h208);
    #2;
    rst = 1'b1;
    #1;
    checkCore("async_reset", 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("async_reset.instr1", instr1, 32'h0);
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, 1'b1, 32'h208, 1'b0, 1'b0, 1'b0, 32'h0);
    checkCore("stale_ack", 1'b0, 32'h0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkCore("restart", 1'b1, 32'h0, 1'b0, 32'h0);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
